counter_seq_checker: RTL

//   Receive-side monitor for the 3-bit Gray up/down counter. Samples the counter state
//   {Q_A,Q_B,Q_C} and its direction input X_1 every enabled cycle.

---
 rtl/counter_seq_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/counter_seq_checker.sv
// Receive-side checker for a 3-bit Gray up/down counter. It locks onto the legal step
// sequence, reports position and direction, and counts illegal transitions while locked.
module counter_seq_checker #(
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Q_A,
  input  logic             Q_B,
  input  logic             Q_C,
  input  logic             X_1,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       position,
  output logic             dir
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e        state_q;
  logic [2:0]    prev_q;
  logic          prev_x;
  logic [GW-1:0] good_run_q;
  logic [BW-1:0] bad_run_q;

  logic [2:0] cur_q;
  logic [2:0] cur_idx;
  logic [2:0] prev_idx;
  logic [2:0] exp_idx;
  logic       legal;
  logic [GW:0] good_inc;
  logic [BW:0] bad_inc;
  logic       good_done;
  logic       bad_done;

  // Gray ring order 000,001,011,010,110,111,101,100 is the reflected code, so this is its index.
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  always_comb begin
    cur_q     = {Q_A, Q_B, Q_C};
    cur_idx   = gray2bin(cur_q);
    prev_idx  = gray2bin(prev_q);
    exp_idx   = prev_x ? prev_idx + 3'd1 : prev_idx - 3'd1;
    legal     = (cur_idx == exp_idx);
    good_inc  = {1'b0, good_run_q} + (GW + 1)'(1);
    bad_inc   = {1'b0, bad_run_q} + (BW + 1)'(1);
    good_done = (good_inc >= (GW + 1)'(LOCK_CNT));
    bad_done  = (bad_inc >= (BW + 1)'(UNLOCK_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHunt;
      prev_q     <= 3'd0;
      prev_x     <= 1'b0;
      good_run_q <= '0;
      bad_run_q  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      position   <= 3'd0;
      dir        <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (en) begin
        // Every sample re-anchors the checker, legal or not.
        prev_q   <= cur_q;
        prev_x   <= X_1;
        position <= cur_idx;
        dir      <= X_1;
        case (state_q)
          StHunt: begin
            state_q    <= StSync;
            good_run_q <= '0;
          end
          StSync: begin
            if (legal) begin
              if (good_done) begin
                state_q    <= StLocked;
                locked     <= 1'b1;
                good_run_q <= '0;
                bad_run_q  <= '0;
              end else begin
                good_run_q <= good_inc[GW-1:0];
              end
            end else begin
              good_run_q <= '0;
            end
          end
          StLocked: begin
            if (legal) begin
              bad_run_q <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (bad_done) begin
                state_q    <= StSync;
                locked     <= 1'b0;
                good_run_q <= '0;
                bad_run_q  <= '0;
              end else begin
                bad_run_q <= bad_inc[BW-1:0];
              end
            end
          end
          default: begin
            state_q <= StHunt;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
